// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every prescale+1 clocks while enabled.
module pwm_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    // >= rather than == so a prescale reduced mid-count still ticks at once.
    assign tick = ena && (pre_cnt >= prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (!ena || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, edge or centre
// aligned, with double-buffered duty values applied at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N          = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [N-1:0]          period,
    input  logic                  center_mode,
    input  logic [CHANNELS*N-1:0] duty_in,
    input  logic                  duty_load,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_end
);

    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic                  tick;
    logic                  boundary;
    logic                  pending;
    logic [N-1:0]          cnt;
    logic [N-1:0]          cnt_nxt;
    pwm_dir_t              dir;
    pwm_dir_t              dir_nxt;
    pwm_mode_t             mode;
    logic [CHANNELS*N-1:0] shadow;
    logic [CHANNELS*N-1:0] active;
    logic [CHANNELS-1:0]   hit;

    assign mode = center_mode ? PWM_CENTER : PWM_EDGE;

    pwm_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .prescale(prescale),
        .tick    (tick)
    );

    // Next counter state for the coming tick; >= compares let a shrunken
    // period wrap or turn immediately instead of running past the top.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (mode == PWM_EDGE) begin
            dir_nxt = DIR_UP;
            if (cnt >= period) begin
                cnt_nxt  = '0;
                boundary = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else if (period == '0) begin
            cnt_nxt  = '0;
            dir_nxt  = DIR_UP;
            boundary = 1'b1;
        end else if (dir == DIR_UP) begin
            if (cnt >= period) begin
                dir_nxt = DIR_DOWN;
                cnt_nxt = cnt - 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            if (cnt == '0) begin
                dir_nxt  = DIR_UP;
                cnt_nxt  = CNT_ONE;
                boundary = 1'b1;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (!ena) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (tick) begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
        end else if (mode == PWM_EDGE) begin
            dir <= DIR_UP;
        end
    end

    // A load on the boundary tick only refills the shadow; it waits a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (duty_load) begin
                shadow <= duty_in;
            end
            if (!ena) begin
                active  <= duty_load ? duty_in : shadow;
                pending <= 1'b0;
            end else begin
                if (tick && boundary && pending) begin
                    active <= shadow;
                end
                pending <= duty_load || (pending && !(tick && boundary));
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [N-1:0] act;
        assign act    = active[i*N +: N];
        assign hit[i] = (act == {N{1'b1}}) || (cnt < act);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out        <= '0;
            period_end <= 1'b0;
        end else begin
            out        <= ena ? hit : '0;
            period_end <= tick && boundary;
        end
    end

endmodule
